// File: rtl/fsm_control.sv
// Transaction-layer control FSM: RESET/INIT/IDLE/ACTIVE/ERROR sequencing,
// threshold latching during INIT and error snapshot on entry to ERROR.
module fsm_control #(
    parameter int UMBRAL_W    = 3,
    parameter int IDLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic                init,
    input  logic [7:0]          empties,
    input  logic [7:0]          error_in,
    input  logic [UMBRAL_W-1:0] umbral_alto_in,
    input  logic [UMBRAL_W-1:0] umbral_bajo_in,
    output logic [3:0]          state,
    output logic [UMBRAL_W-1:0] umbral_alto,
    output logic [UMBRAL_W-1:0] umbral_bajo,
    output logic                idle_out,
    output logic                active_out,
    output logic                error_out,
    output logic [7:0]          error_fifo
);

    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000,
        ST_ERROR  = 4'b1111
    } state_e;

    localparam logic [3:0] IDLE_N = IDLE_CYCLES[3:0];

    state_e              state_q, state_d;
    logic [UMBRAL_W-1:0] alto_q, alto_d;
    logic [UMBRAL_W-1:0] bajo_q, bajo_d;
    logic [7:0]          efifo_q, efifo_d;
    logic [3:0]          cnt_q, cnt_d;

    logic                err_any;
    logic                all_empty;
    logic [3:0]          cnt_inc;

    // Next-state, threshold, snapshot and idle-counter computation
    always_comb begin
        state_d   = state_q;
        alto_d    = alto_q;
        bajo_d    = bajo_q;
        efifo_d   = efifo_q;
        cnt_d     = 4'd0;
        err_any   = |error_in;
        all_empty = &empties;
        cnt_inc   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

        unique case (state_q)
            ST_RESET: begin
                state_d = ST_INIT;
            end
            ST_INIT: begin
                alto_d = umbral_alto_in;
                bajo_d = umbral_bajo_in;
                if (err_any) begin
                    state_d = ST_ERROR;
                    efifo_d = error_in;
                end else if (!init) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (err_any) begin
                    state_d = ST_ERROR;
                    efifo_d = error_in;
                end else if (init) begin
                    state_d = ST_INIT;
                end else if (!all_empty) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (err_any) begin
                    state_d = ST_ERROR;
                    efifo_d = error_in;
                end else if (init) begin
                    state_d = ST_INIT;
                end else if (all_empty) begin
                    if (cnt_inc >= IDLE_N) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset_L
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_RESET;
            alto_q  <= '0;
            bajo_q  <= '0;
            efifo_q <= 8'h00;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            alto_q  <= alto_d;
            bajo_q  <= bajo_d;
            efifo_q <= efifo_d;
            cnt_q   <= cnt_d;
        end
    end

    // Status flags decoded from the registered state
    always_comb begin
        state       = state_q;
        umbral_alto = alto_q;
        umbral_bajo = bajo_q;
        error_fifo  = efifo_q;
        idle_out    = (state_q == ST_IDLE);
        active_out  = (state_q == ST_ACTIVE);
        error_out   = (state_q == ST_ERROR);
    end

endmodule

// File: tb/tb_fsm_control.sv
// Directed bench for fsm_control: driver queues hand-computed expectations,
// a monitor pops one per clock and compares against the DUT outputs.
module tb_fsm_control;

    localparam logic [3:0] S_RST = 4'b0001;
    localparam logic [3:0] S_INI = 4'b0010;
    localparam logic [3:0] S_IDL = 4'b0100;
    localparam logic [3:0] S_ACT = 4'b1000;
    localparam logic [3:0] S_ERR = 4'b1111;

    typedef struct {
        string      name;
        logic [3:0] st;
        logic [2:0] ua;
        logic [2:0] ub;
        logic [7:0] ef;
    } exp_t;

    logic       clk;
    logic       reset_L;
    logic       init;
    logic [7:0] empties;
    logic [7:0] error_in;
    logic [2:0] umbral_alto_in;
    logic [2:0] umbral_bajo_in;
    logic [3:0] state;
    logic [2:0] umbral_alto;
    logic [2:0] umbral_bajo;
    logic       idle_out;
    logic       active_out;
    logic       error_out;
    logic [7:0] error_fifo;

    int   checks;
    int   failures;
    exp_t sb[$];

    fsm_control #(.UMBRAL_W(3), .IDLE_CYCLES(2)) dut (
        .clk            (clk),
        .reset_L        (reset_L),
        .init           (init),
        .empties        (empties),
        .error_in       (error_in),
        .umbral_alto_in (umbral_alto_in),
        .umbral_bajo_in (umbral_bajo_in),
        .state          (state),
        .umbral_alto    (umbral_alto),
        .umbral_bajo    (umbral_bajo),
        .idle_out       (idle_out),
        .active_out     (active_out),
        .error_out      (error_out),
        .error_fifo     (error_fifo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic compare(input exp_t e);
        chk({e.name, ".state"}, {4'h0, state}, {4'h0, e.st});
        chk({e.name, ".ualto"}, {5'h0, umbral_alto}, {5'h0, e.ua});
        chk({e.name, ".ubajo"}, {5'h0, umbral_bajo}, {5'h0, e.ub});
        chk({e.name, ".efifo"}, error_fifo, e.ef);
        chk({e.name, ".idle"}, {7'h0, idle_out},
            {7'h0, e.st == S_IDL});
        chk({e.name, ".active"}, {7'h0, active_out},
            {7'h0, e.st == S_ACT});
        chk({e.name, ".error"}, {7'h0, error_out},
            {7'h0, e.st == S_ERR});
    endtask

    // Drive one cycle of inputs and queue the state expected after the edge
    task automatic step(input string nm, input logic rst,
                        input logic in_init, input logic [7:0] emp,
                        input logic [7:0] err, input logic [2:0] ua_in,
                        input logic [2:0] ub_in, input logic [3:0] st,
                        input logic [2:0] ua, input logic [2:0] ub,
                        input logic [7:0] ef);
        exp_t e;
        @(negedge clk);
        reset_L        = rst;
        init           = in_init;
        empties        = emp;
        error_in       = err;
        umbral_alto_in = ua_in;
        umbral_bajo_in = ub_in;
        e.name = nm;
        e.st   = st;
        e.ua   = ua;
        e.ub   = ub;
        e.ef   = ef;
        sb.push_back(e);
    endtask

    // Monitor: one expectation consumed per rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) compare(sb.pop_front());
        end
    end

    initial begin
        exp_t z;
        checks         = 0;
        failures       = 0;
        reset_L        = 1'b0;
        init           = 1'b0;
        empties        = 8'hFF;
        error_in       = 8'h00;
        umbral_alto_in = 3'd0;
        umbral_bajo_in = 3'd0;

        repeat (3) step("rst", 0, 0, 8'hFF, 8'h00, 0, 0, S_RST, 0, 0, 8'h00);
        step("rel", 1, 1, 8'hFF, 8'h00, 6, 1, S_INI, 0, 0, 8'h00);
        step("ini", 1, 1, 8'hFF, 8'h00, 6, 1, S_INI, 6, 1, 8'h00);
        step("ini_x", 1, 0, 8'hFF, 8'h00, 6, 1, S_IDL, 6, 1, 8'h00);
        step("idl", 1, 0, 8'hFF, 8'h00, 6, 1, S_IDL, 6, 1, 8'h00);

        step("go", 1, 0, 8'hFE, 8'h00, 6, 1, S_ACT, 6, 1, 8'h00);
        step("e1", 1, 0, 8'hFF, 8'h00, 6, 1, S_ACT, 6, 1, 8'h00);
        step("e2", 1, 0, 8'hFF, 8'h00, 6, 1, S_IDL, 6, 1, 8'h00);

        step("go2", 1, 0, 8'hFE, 8'h00, 6, 1, S_ACT, 6, 1, 8'h00);
        step("f1", 1, 0, 8'hFF, 8'h00, 6, 1, S_ACT, 6, 1, 8'h00);
        step("fb", 1, 0, 8'hFB, 8'h00, 6, 1, S_ACT, 6, 1, 8'h00);
        step("f2", 1, 0, 8'hFF, 8'h00, 6, 1, S_ACT, 6, 1, 8'h00);
        step("f3", 1, 0, 8'hFF, 8'h00, 6, 1, S_IDL, 6, 1, 8'h00);

        step("go3", 1, 0, 8'hFE, 8'h00, 6, 1, S_ACT, 6, 1, 8'h00);
        step("rei", 1, 1, 8'hFE, 8'h00, 3, 1, S_INI, 6, 1, 8'h00);
        step("rei_x", 1, 0, 8'hFE, 8'h00, 3, 1, S_IDL, 3, 1, 8'h00);
        step("ua7", 1, 0, 8'hFF, 8'h00, 7, 2, S_IDL, 3, 1, 8'h00);
        step("go4", 1, 0, 8'hFE, 8'h00, 7, 2, S_ACT, 3, 1, 8'h00);

        step("err", 1, 1, 8'hFE, 8'h24, 7, 2, S_ERR, 3, 1, 8'h24);
        step("stk1", 1, 1, 8'hFE, 8'h81, 5, 5, S_ERR, 3, 1, 8'h24);
        step("stk2", 1, 0, 8'hFF, 8'h00, 5, 5, S_ERR, 3, 1, 8'h24);

        @(posedge clk);
        #3;
        reset_L = 1'b0;
        #1;
        z.name = "async";
        z.st   = S_RST;
        z.ua   = 3'd0;
        z.ub   = 3'd0;
        z.ef   = 8'h00;
        compare(z);

        step("rst2", 0, 1, 8'hFE, 8'hFF, 5, 5, S_RST, 0, 0, 8'h00);
        step("rel2", 1, 0, 8'hFE, 8'hFF, 5, 5, S_INI, 0, 0, 8'h00);
        step("ierr", 1, 0, 8'hFF, 8'h02, 4, 2, S_ERR, 4, 2, 8'h02);
        step("ierr_h", 1, 1, 8'hFF, 8'h00, 1, 1, S_ERR, 4, 2, 8'h02);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0",
                     sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
